// File: rtl/friscv_ifetch.sv
// Instruction fetch stage: drives the instruction SRAM read port, absorbs its 1-cycle latency and
// buffers {pc, instr} pairs for decode behind a valid/ready handshake with redirect flush.
module friscv_ifetch #(
  parameter int unsigned ARCH = 32,
  parameter int unsigned IMEM_DEPTH = 4096,
  parameter logic [ARCH-1:0] RESET_VECTOR = '0,
  parameter int unsigned FIFO_DEPTH = 2,
  localparam int unsigned AW = $clog2(IMEM_DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [AW-1:0]   imem_addr_b_byte_out,
  output logic            imem_en_b_out,
  input  logic [ARCH-1:0] imem_dout_b_in,
  input  logic            redirect_in,
  input  logic [ARCH-1:0] redirect_pc_in,
  output logic            instr_valid_out,
  input  logic            instr_ready_in,
  output logic [ARCH-1:0] instr_out,
  output logic [ARCH-1:0] pc_out
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [0:0] {StBoot, StRun} state_e;

  state_e state_q, state_d;
  logic   boot_wait_q;

  logic [ARCH-1:0] fetch_pc_q;
  logic [ARCH-1:0] issued_pc_q;
  logic            inflight_q;

  logic [ARCH-1:0] fifo_instr_q [FIFO_DEPTH];
  logic [ARCH-1:0] fifo_pc_q    [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q;

  logic            pop;
  logic            push;
  logic [CW:0]     occupancy;
  logic [ARCH-1:0] redirect_pc_aligned;

  assign redirect_pc_aligned = redirect_pc_in & ~ARCH'(3);

  assign instr_valid_out      = (count_q != '0);
  assign instr_out            = fifo_instr_q[rd_ptr_q];
  assign pc_out               = fifo_pc_q[rd_ptr_q];
  assign imem_addr_b_byte_out = fetch_pc_q[AW-1:0];

  assign pop  = instr_valid_out & instr_ready_in;
  // A response returning during a redirect belongs to the old stream and is dropped.
  assign push = inflight_q & ~redirect_in;

  // boot_wait_q stretches BOOT so it covers the first cycle after reset release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StBoot;
      boot_wait_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      boot_wait_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot: if (!boot_wait_q) state_d = StRun;
      StRun:  state_d = StRun;
    endcase
  end

  always_comb begin
    occupancy     = (CW+1)'(count_q) + (CW+1)'(inflight_q) - (CW+1)'(pop);
    imem_en_b_out = (state_q == StRun) && !redirect_in && (occupancy < (CW+1)'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q  <= RESET_VECTOR;
      issued_pc_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      if (redirect_in) begin
        fetch_pc_q <= redirect_pc_aligned;
      end else if (imem_en_b_out) begin
        fetch_pc_q <= fetch_pc_q + ARCH'(4);
      end
      if (imem_en_b_out) begin
        issued_pc_q <= fetch_pc_q;
      end
      inflight_q <= imem_en_b_out;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
    end else if (redirect_in) begin
      // Flush wins over a simultaneous pop.
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_instr_q[wr_ptr_q] <= imem_dout_b_in;
        fifo_pc_q[wr_ptr_q]    <= issued_pc_q;
        wr_ptr_q               <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && !pop && (count_q == CW'(FIFO_DEPTH))));
    end
  end

endmodule

// File: doc/friscv_ifetch.md
Name: friscv_ifetch

Overview:
- Instruction fetch stage that drives the read port (port B) of the 4 KiB instruction SRAM and consumes its registered read data.
- Keeps a fetch PC and issues word reads; absorbs the 1-cycle SRAM read latency.
- Buffers fetched {pc, instr} pairs in a small FIFO and hands them to decode over a valid/ready handshake.
- Supports a redirect (branch/jump/trap) that flushes all buffered and in-flight fetches.

Parameters:
- ARCH, 32, instruction/PC width in bits (friscv_pkg ARCH).
- IMEM_DEPTH, 4096, instruction SRAM size in bytes; address width AW = $clog2(IMEM_DEPTH).
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, output buffer entries; must be ≥2 and a power of 2.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- imem_addr_b_byte_out  output  AW  byte read address to SRAM port B; always word-aligned.
- imem_en_b_out  output  1  SRAM port B read enable.
- imem_dout_b_in  input  ARCH  SRAM read data; valid the cycle after imem_en_b_out was high.
- redirect_in  input  1  flush and restart fetch at redirect_pc_in.
- redirect_pc_in  input  ARCH  new fetch PC; bits [1:0] are ignored and forced to 0.
- instr_valid_out  output  1  FIFO head is valid.
- instr_ready_in  input  1  decode accepts the head this cycle.
- instr_out  output  ARCH  instruction at the FIFO head.
- pc_out  output  ARCH  PC of instr_out.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state <= BOOT; fetch_pc <= RESET_VECTOR; FIFO count <= 0; inflight <= 0.
  - Outputs: imem_en_b_out=0, instr_valid_out=0, imem_addr_b_byte_out=RESET_VECTOR[AW-1:0], instr_out=0, pc_out=0.
  - Reset asserted mid-operation discards all FIFO contents and the in-flight read.
- FSM has two states:
  - BOOT: en=0 for one cycle, then → RUN unconditionally.
  - RUN: normal operation; returns to BOOT only on reset.
- Read issue in RUN:
  - pop = instr_valid_out & instr_ready_in.
  - imem_en_b_out = !redirect_in & ((count + inflight − pop) < FIFO_DEPTH).
  - imem_addr_b_byte_out = fetch_pc[AW-1:0] (combinational from the register).
  - When en=1: fetch_pc <= fetch_pc + 4 (ARCH-bit wrap), inflight <= 1, and the issued PC is registered alongside.
  - When en=0: inflight <= 0.
- Response capture:
  - If inflight=1 and redirect_in=0, {issued_pc, imem_dout_b_in} is pushed into the FIFO at the next edge.
  - The issue rule guarantees the FIFO never overflows; push while full is an assertion failure.
- Output:
  - instr_valid_out = (count ≠ 0), registered head, no bypass.
  - Push and pop in the same cycle: count is unchanged and order is preserved.
  - instr_out and pc_out stay stable while valid=1 and ready=0.
- Redirect (redirect_in=1 in RUN):
  - At the edge: FIFO flushed (count <= 0), the response arriving that cycle is dropped, fetch_pc <= {redirect_pc_in[ARCH-1:2], 2'b00}.
  - en=0 during the redirect cycle; instr_valid_out=0 from the next cycle.
  - First read at the new PC is issued the cycle after the redirect.
  - A pop and a redirect in the same cycle: the flush wins; the pop is still counted as accepted by decode.
  - Redirect during BOOT updates fetch_pc only.
- Latency:
  - Let E0 be the first edge with rst_n=1.
  - BOOT lasts until E1; en=1 with addr=RESET_VECTOR during E1–E2; SRAM data is valid E2–E3; pushed at E3; instr_valid_out=1 after E3.
  - Redirect to first valid instruction: 3 cycles.
- Throughput: 1 instruction/cycle sustained with instr_ready_in held high and FIFO_DEPTH ≥ 2.
- Address wrap:
  - pc_out carries the full ARCH-bit PC.
  - The SRAM address is truncated to AW bits, so PC 0x1000 reads SRAM byte 0x000.

Test Plan:
- Reset release, ready=1, SRAM preloaded with word n = 0x1000_0000+n → valid first asserts 3 cycles after E0 with pc_out=0x0, instr_out=0x1000_0000, then one per cycle: pc 0x4, 0x8, 0xC, …
- ready=0 for 10 cycles after first valid → exactly FIFO_DEPTH entries buffered, en=0 while full, head held at pc=0x0; on ready=1, pc 0x0, 0x4, … are delivered with no gap or duplicate.
- Redirect to 0x0000_0203 while the FIFO is full and a read is in flight → no old entry is delivered after the redirect cycle; first valid after 3 cycles has pc_out=0x200 and instr_out = the word at 0x200.
- Redirect asserted in the same cycle as a pop and a returning read → the returning word is dropped, count=0 the next cycle, and the sequence restarts at redirect_pc.
- Fetch across 0xFFC with ready=1 → pc_out 0xFFC then 0x1000; imem_addr_b_byte_out goes 0xFFC → 0x000; instr_out equals the SRAM word 0.
- rst_n=0 for one cycle mid-stream → valid=0 and en=0 the next cycle; fetch restarts from RESET_VECTOR with the same 3-cycle latency.
